regfile_arbiter: RTL

//  Shares the 10-entry x 64-bit register file between two requesters:
//  P0 (core execute stage) and P1 (debug/monitor port).

---
 rtl/regfile_arbiter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/regfile_arbiter.sv
// Two-port arbiter for the 10 x 64-bit register file.
// Serialises P0/P1 accesses, drives sel/load/d and registers the read buses.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   pN_req/we/ra/rb     port N request, write enable, A code, B/write code
//   pN_wdata            port N write data
//   p0_lock             P0 keeps ownership after this access
//   pN_gnt, pN_err      one-cycle done pulse, invalid-code flag
//   rdata_a, rdata_b    captured read buses, valid with either gnt
//   rf_sel/rf_load/rf_d register file select {A,B}, write strobe, data
//   rf_a, rf_b          register file read buses
module regfile_arbiter #(
    parameter int W    = 64,
    parameter int NREG = 10
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         p0_req,
    input  logic         p0_we,
    input  logic [3:0]   p0_ra,
    input  logic [3:0]   p0_rb,
    input  logic [W-1:0] p0_wdata,
    input  logic         p0_lock,
    output logic         p0_gnt,
    output logic         p0_err,

    input  logic         p1_req,
    input  logic         p1_we,
    input  logic [3:0]   p1_ra,
    input  logic [3:0]   p1_rb,
    input  logic [W-1:0] p1_wdata,
    output logic         p1_gnt,
    output logic         p1_err,

    output logic [W-1:0] rdata_a,
    output logic [W-1:0] rdata_b,

    output logic [7:0]   rf_sel,
    output logic         rf_load,
    output logic [W-1:0] rf_d,
    input  logic [W-1:0] rf_a,
    input  logic [W-1:0] rf_b
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // 5 bits so that NREG up to 16 still compares correctly
    localparam logic [4:0] NREG_C = 5'(NREG);

    function automatic logic code_ok(input logic [3:0] c);
        return {1'b0, c} < NREG_C;
    endfunction

    state_t       state_q, state_d;

    // latched access; win_q: 0 = P0, 1 = P1
    logic         win_q, win_d;
    logic         we_q, we_d;
    logic [3:0]   ra_q, ra_d;
    logic [3:0]   rb_q, rb_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic         err_q, err_d;

    // rr_q names the port that wins a contested IDLE
    logic         rr_q, rr_d;
    logic         lock_q, lock_d;

    logic [W-1:0] rdata_a_q, rdata_a_d;
    logic [W-1:0] rdata_b_q, rdata_b_d;

    logic         any_req;
    logic         pick_p1;

    // ------------------------------------------------------------
    // Arbitration: lock beats round-robin, round-robin beats the
    // other port, and a lone requester always wins.
    // ------------------------------------------------------------
    always_comb begin
        any_req = p0_req | p1_req;
        pick_p1 = 1'b0;
        if (lock_q && p0_req) begin
            pick_p1 = 1'b0;
        end else if (rr_q) begin
            pick_p1 = p1_req;
        end else begin
            pick_p1 = !p0_req;
        end
    end

    // ------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (any_req) state_d = S_ACCESS;
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------
    // Access latch, read capture, fairness and lock bookkeeping
    // ------------------------------------------------------------
    always_comb begin
        win_d     = win_q;
        we_d      = we_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rr_d      = rr_q;
        lock_d    = lock_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;

        unique case (state_q)
            S_IDLE: begin
                // P0 walking away releases a held lock
                if (lock_q && !p0_req) begin
                    lock_d = 1'b0;
                end
                if (any_req) begin
                    win_d = pick_p1;
                    if (pick_p1) begin
                        we_d    = p1_we;
                        ra_d    = p1_ra;
                        rb_d    = p1_rb;
                        wdata_d = p1_wdata;
                        err_d   = !(code_ok(p1_ra) && code_ok(p1_rb));
                    end else begin
                        we_d    = p0_we;
                        ra_d    = p0_ra;
                        rb_d    = p0_rb;
                        wdata_d = p0_wdata;
                        err_d   = !(code_ok(p0_ra) && code_ok(p0_rb));
                    end
                end
            end
            S_ACCESS: begin
                // the write lands on this same edge, so B is the old value
                rdata_a_d = err_q ? '0 : rf_a;
                rdata_b_d = err_q ? '0 : rf_b;
            end
            S_DONE: begin
                rr_d   = ~win_q;
                lock_d = !win_q && p0_lock;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            ra_q      <= '0;
            rb_q      <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rr_q      <= 1'b0;
            lock_q    <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            we_q      <= we_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    // ------------------------------------------------------------
    // FSM: outputs. Register file is only touched in ACCESS, and
    // never for an invalid code.
    // ------------------------------------------------------------
    always_comb begin
        rf_sel  = 8'hFF;
        rf_load = 1'b0;
        rf_d    = '0;
        p0_gnt  = 1'b0;
        p1_gnt  = 1'b0;
        p0_err  = 1'b0;
        p1_err  = 1'b0;

        unique case (state_q)
            S_ACCESS: begin
                if (!err_q) begin
                    rf_sel  = {ra_q, rb_q};
                    rf_load = we_q;
                    rf_d    = wdata_q;
                end
            end
            S_DONE: begin
                p0_gnt = !win_q;
                p1_gnt = win_q;
                p0_err = !win_q && err_q;
                p1_err = win_q && err_q;
            end
            default: ;
        endcase
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule
